// File: rtl/core_pkg.sv
// Shared RV32IC front-end definitions: halfword/instruction widths and the
// compressed-instruction test used by the fetch realigner.
package core_pkg;

    localparam int HW_W = 16;
    localparam int ILEN = 32;

    typedef logic [31:0] fetch_pkt_t;

    // A parcel whose two LSBs are not 2'b11 starts a 16-bit instruction.
    function automatic logic is_compressed(input logic [1:0] lsbs);
        return lsbs != 2'b11;
    endfunction

endpackage

// File: rtl/hw_fifo.sv
// Circular halfword buffer with an N-wide push (leading halfwords optionally
// skipped), a 1-or-2 halfword pop and a synchronous flush.
module hw_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int NPUSH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    push_en,
    input  logic [NPUSH*HW_W-1:0]   push_data,
    input  logic [1:0]              push_skip,
    input  logic                    pop_en,
    input  logic                    pop_two,
    output logic [HW_W-1:0]         h0,
    output logic [HW_W-1:0]         h1,
    output logic [CW-1:0]           count
);

    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   push_cnt;
    logic [CW-1:0]   pop_cnt;
    logic [HW_W-1:0] mem     [DEPTH];
    logic [DEPTH-1:0] wr_en;
    logic [HW_W-1:0] wr_data [DEPTH];

    assign push_cnt = CW'(NPUSH) - CW'(push_skip);
    assign pop_cnt  = pop_two ? CW'(2) : CW'(1);

    // Skipped lanes shift the surviving halfwords down so they land at the tail.
    always_comb begin
        wr_en   = '0;
        wr_data = '{default: '0};
        for (int i = 0; i < NPUSH; i++) begin
            if (push_en && !flush && (i >= int'(push_skip))) begin
                wr_en[tail + PW'(i) - PW'(push_skip)]   = 1'b1;
                wr_data[tail + PW'(i) - PW'(push_skip)] = push_data[i*HW_W +: HW_W];
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic [HW_W-1:0] entry_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                entry_q <= '0;
            end else if (wr_en[g]) begin
                entry_q <= wr_data[g];
            end
        end
        assign mem[g] = entry_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_en) begin
                tail <= tail + push_cnt[PW-1:0];
            end
            if (pop_en) begin
                head <= head + pop_cnt[PW-1:0];
            end
            count <= count + (push_en ? push_cnt : '0) - (pop_en ? pop_cnt : '0);
        end
    end

    assign h0 = mem[head];
    assign h1 = mem[head + PW'(1)];

endmodule

// File: rtl/compressed_realigner.sv
// Realigns fetch packets into one 32-bit or 16-bit instruction per cycle,
// tracking the instruction PC and halfword-aligned redirect targets.
module compressed_realigner
    import core_pkg::*;
#(
    parameter int          FETCH_W  = 32,
    parameter int          DEPTH_HW = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    input  logic               fetch_valid,
    output logic               fetch_ready,
    input  logic [FETCH_W-1:0] fetch_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ILEN-1:0]    instr,
    output logic [31:0]        instr_pc,
    output logic               instr_compressed
);

    localparam int NHW = FETCH_W / HW_W;
    localparam int PW  = $clog2(DEPTH_HW);
    localparam int CW  = PW + 1;

    logic [CW-1:0]   count;
    logic [HW_W-1:0] h0;
    logic [HW_W-1:0] h1;
    logic [31:0]     out_pc;
    logic [1:0]      skip_hw;
    logic            compressed;
    logic            push;
    logic            pop;
    logic            flush;

    assign compressed  = is_compressed(h0[1:0]);
    assign instr_valid = ((count >= CW'(1)) && compressed) || (count >= CW'(2));
    assign fetch_ready = count <= CW'(DEPTH_HW - NHW);

    assign instr            = compressed ? {16'h0000, h0} : {h1, h0};
    assign instr_pc         = out_pc;
    assign instr_compressed = compressed;

    // Redirect and clear both squash any handshake landing in the same cycle.
    assign flush = redirect || clear;
    assign push  = fetch_valid && fetch_ready && !flush;
    assign pop   = instr_valid && instr_ready && !flush;

    hw_fifo #(
        .DEPTH (DEPTH_HW),
        .NPUSH (NHW)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .push_en   (push),
        .push_data (fetch_data),
        .push_skip (skip_hw),
        .pop_en    (pop),
        .pop_two   (!compressed),
        .h0        (h0),
        .h1        (h1),
        .count     (count)
    );

    // Packets arrive aligned to their own width, so a redirect into the middle
    // of one drops the halfwords below the target on the next push.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_pc  <= RESET_PC;
            skip_hw <= '0;
        end else if (redirect) begin
            out_pc  <= redirect_pc & 32'hFFFF_FFFE;
            skip_hw <= (FETCH_W == 32) ? {1'b0, redirect_pc[1]} : redirect_pc[2:1];
        end else if (clear) begin
            skip_hw <= '0;
        end else begin
            if (push) begin
                skip_hw <= '0;
            end
            if (pop) begin
                out_pc <= out_pc + (compressed ? 32'd2 : 32'd4);
            end
        end
    end

endmodule

// File: tb/tb_compressed_realigner.sv
// Randomized and directed bench for compressed_realigner against a halfword
// queue model of the buffer, PC and redirect skip.
module tb_compressed_realigner;

    localparam int          FETCH_W  = 32;
    localparam int          DEPTH_HW = 8;
    localparam logic [31:0] RESET_PC = 32'h0000_1000;

    logic        clk;
    logic        reset_n;
    logic        clear;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_compressed;

    int checks;
    int failures;

    logic [15:0] mq[$];
    logic [31:0] mpc;
    logic        mskip;

    compressed_realigner #(
        .FETCH_W  (FETCH_W),
        .DEPTH_HW (DEPTH_HW),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .clear            (clear),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .fetch_valid      (fetch_valid),
        .fetch_ready      (fetch_ready),
        .fetch_data       (fetch_data),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .instr_compressed (instr_compressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic modelComp();
        return (mq.size() >= 1) ? (mq[0][1:0] != 2'b11) : 1'b1;
    endfunction

    function automatic logic modelValid();
        return ((mq.size() >= 1) && modelComp()) || (mq.size() >= 2);
    endfunction

    function automatic logic modelReady();
        return (DEPTH_HW - mq.size()) >= (FETCH_W / 16);
    endfunction

    task automatic compareModel(input string tag);
        logic [31:0] exp_instr;
        checkOutput({tag, ".valid"}, 32'(instr_valid), 32'(modelValid()));
        checkOutput({tag, ".ready"}, 32'(fetch_ready), 32'(modelReady()));
        checkOutput({tag, ".pc"}, instr_pc, mpc);
        if (mq.size() >= 1) begin
            checkOutput({tag, ".comp"}, 32'(instr_compressed), 32'(modelComp()));
        end
        if (modelValid()) begin
            if (modelComp()) exp_instr = {16'h0000, mq[0]};
            else             exp_instr = {mq[1], mq[0]};
            checkOutput({tag, ".instr"}, instr, exp_instr);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model, then compare.
    task automatic applyStimulus(input logic fv, input logic [31:0] fd, input logic ir,
                                 input logic rd, input logic [31:0] rpc, input logic clr,
                                 input string tag);
        logic pre_valid, pre_ready, pre_comp;
        fetch_valid = fv;
        fetch_data  = fd;
        instr_ready = ir;
        redirect    = rd;
        redirect_pc = rpc;
        clear       = clr;
        @(posedge clk);
        pre_valid = modelValid();
        pre_ready = modelReady();
        pre_comp  = modelComp();
        if (rd) begin
            mq.delete();
            mpc   = rpc & 32'hFFFF_FFFE;
            mskip = rpc[1];
        end else if (clr) begin
            mq.delete();
            mskip = 1'b0;
        end else begin
            if (pre_valid && ir) begin
                void'(mq.pop_front());
                if (!pre_comp) void'(mq.pop_front());
                mpc = mpc + (pre_comp ? 32'd2 : 32'd4);
            end
            if (fv && pre_ready) begin
                if (!mskip) mq.push_back(fd[15:0]);
                mq.push_back(fd[31:16]);
                mskip = 1'b0;
            end
        end
        #1;
        compareModel(tag);
    endtask

    task automatic resetModel();
        mq.delete();
        mpc   = RESET_PC;
        mskip = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset_n     = 1'b0;
        clear       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        fetch_valid = 1'b0;
        fetch_data  = '0;
        instr_ready = 1'b0;
        resetModel();

        #23 reset_n = 1'b1;
        #1;
        checkOutput("rst.valid", 32'(instr_valid), 32'd0);
        checkOutput("rst.ready", 32'(fetch_ready), 32'd1);
        checkOutput("rst.instr", instr, 32'd0);
        checkOutput("rst.comp", 32'(instr_compressed), 32'd1);
        checkOutput("rst.pc", instr_pc, RESET_PC);

        // Two compressed instructions in one packet.
        applyStimulus(1'b1, 32'h4501_0001, 1'b0, 1'b0, '0, 1'b0, "c2a");
        checkOutput("c2a.instr_k", instr, 32'h0000_0001);
        checkOutput("c2a.pc_k", instr_pc, RESET_PC);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, "c2b");
        checkOutput("c2b.instr_k", instr, 32'h0000_4501);
        checkOutput("c2b.pc_k", instr_pc, RESET_PC + 32'd2);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, "c2c");

        // 32-bit instruction straddling two packets.
        applyStimulus(1'b1, 32'h0093_4501, 1'b0, 1'b0, '0, 1'b0, "st1");
        checkOutput("st1.instr_k", instr, 32'h0000_4501);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, "st2");
        checkOutput("st2.valid_k", 32'(instr_valid), 32'd0);
        applyStimulus(1'b1, 32'h0000_0010, 1'b0, 1'b0, '0, 1'b0, "st3");
        checkOutput("st3.instr_k", instr, 32'h0010_0093);
        checkOutput("st3.pc_k", instr_pc, RESET_PC + 32'd6);
        checkOutput("st3.comp_k", 32'(instr_compressed), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, "st4");

        // Redirect to an odd halfword drops the low half of the next packet.
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h0000_0102, 1'b0, "rd1");
        checkOutput("rd1.valid_k", 32'(instr_valid), 32'd0);
        applyStimulus(1'b1, 32'h0001_ABCD, 1'b0, 1'b0, '0, 1'b0, "rd2");
        checkOutput("rd2.instr_k", instr, 32'h0000_0001);
        checkOutput("rd2.pc_k", instr_pc, 32'h0000_0102);

        // Fill to full with 32-bit instructions, then free one slot pair.
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, "clr");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, {16'h1000 + 16'(k), 16'h0013}, 1'b0, 1'b0, '0, 1'b0, "fill");
        end
        checkOutput("full.ready_k", 32'(fetch_ready), 32'd0);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, '0, 1'b0, "drain");
        checkOutput("drain.ready_k", 32'(fetch_ready), 32'd1);
        checkOutput("drain.instr_k", instr, 32'h1001_0013);

        // Redirect beats clear, push and pop in the same cycle.
        applyStimulus(1'b1, 32'h0001_0001, 1'b1, 1'b1, 32'h0000_0200, 1'b1, "rall");
        checkOutput("rall.valid_k", 32'(instr_valid), 32'd0);
        checkOutput("rall.pc_k", instr_pc, 32'h0000_0200);

        for (int n = 0; n < 600; n++) begin
            logic        fv, ir, rd, clr;
            logic [31:0] rpc;
            fv  = ($urandom_range(0, 99) < 60);
            ir  = ($urandom_range(0, 99) < 55);
            rd  = ($urandom_range(0, 99) < 5);
            clr = ($urandom_range(0, 99) < 3);
            rpc = $urandom & 32'h0000_FFFE;
            applyStimulus(fv, $urandom, ir, rd, rpc, clr, "rnd");
        end

        // Asynchronous reset between edges while instructions are buffered.
        applyStimulus(1'b1, 32'h0093_0001, 1'b0, 1'b0, '0, 1'b0, "pre");
        #3 reset_n = 1'b0;
        #1;
        checkOutput("arst.valid", 32'(instr_valid), 32'd0);
        checkOutput("arst.ready", 32'(fetch_ready), 32'd1);
        checkOutput("arst.pc", instr_pc, RESET_PC);
        resetModel();
        fetch_valid = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b1;
        applyStimulus(1'b1, 32'h4501_0001, 1'b0, 1'b0, '0, 1'b0, "post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
